imm_operand_encoder: RTL and testbench
======================================

# imm_operand_encoder

Sequential encoder that converts a 32-bit constant into the 12-bit shift-operand immediate field consumed by the execute stage's operand-2 generator. It is the inverse of that generator's immediate path. It searches the 16 rotation amounts one per cycle and reports whether, and how, the constant can be encoded. It also handles the 12-bit signed load/store offset form in a single step. It sits in the instruction-build path, where it supplies encoded immediates to the pipeline test loader and assembler hardware.

## Interface
- No parameters; all widths are fixed by the instruction format.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only while busy=0
- ld_str  input  1  1: encode as 12-bit signed memory offset; 0: encode as rotated 8-bit immediate
- value  input  32  constant to encode; captured on the accepted start edge
- busy  output  1  high from the edge after start is accepted until done falls
- done  output  1  one-cycle completion pulse
- found  output  1  valid with done; 1 means value is encodable
- shift_operand  output  12  encoded field; valid with done

## Operation
- Decoder semantics to invert:
  - Immediate form: value = ROR({{24{imm8[7]}}, imm8}, 2*rot), with shift_operand = {rot[3:0], imm8[7:0]}.
  - Offset form: value = sign-extend(shift_operand[11:0]).
- States:
  - IDLE, SEARCH, DONE.
  - A 4-bit rotation counter r and a 32-bit value register v.
- IDLE:
  - When start=1, capture value into v and clear r.
  - If ld_str=1, go to DONE. found = (v[31:11] all equal), and shift_operand = found ? v[11:0] : 12'h000.
  - If ld_str=0, go to SEARCH.
- SEARCH, each cycle:
  - Compute w = ROL(v, 2*r).
  - Fit test: w[31:7] is all zeros or all ones.
  - On fit, set shift_operand = {r, w[7:0]}, set found=1, and go to DONE.
  - On no fit with r=15, set shift_operand = 12'h000, set found=0, and go to DONE.
  - Otherwise increment r.
- The search always takes the smallest r that fits, so the encoding is unique and deterministic.
- DONE:
  - done=1 for exactly this one cycle, then return to IDLE.
- found and shift_operand hold their last values until the next DONE.
- start while busy=1 is ignored; no queueing.
- start and rst in the same cycle: rst wins.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, found=0, shift_operand=12'h000.
  - r=0, v=0.
- Cycle numbering: start is high in cycle 0 and sampled at the end of cycle 0.
- Offset form: done is high in cycle 1; busy is high in cycle 1 only.
- Immediate form, first fit at r=k: SEARCH occupies cycles 1..k+1 and done is high in cycle k+2.
- Immediate form, no fit: done is high in cycle 17.
- busy = (state != IDLE). A new start is first accepted in the cycle after done.
- Back-to-back throughput:
  - Minimum 2 cycles per request in offset form.
  - k+3 cycles per request in immediate form.
- Reset mid-search: the next state is IDLE and all outputs return to their reset values. The request is discarded, and no done is issued for it.
- value and ld_str are don't-care except on the accepted start edge.

## Test plan
- ld_str=0, value=32'hFFFFFF80 -> done in cycle 2, found=1, shift_operand=12'h080.
- ld_str=0, value=32'h3F000000 -> done in cycle 6, found=1, shift_operand=12'h43F.
- ld_str=0, value=32'h00000080 -> done in cycle 15, found=1, shift_operand=12'hD02. Also value=32'h000000FF -> done in cycle 17, found=0, shift_operand=12'h000.
- ld_str=1, value=32'hFFFFF800 -> done in cycle 1, found=1, shift_operand=12'h800. Also value=32'h00000800 -> found=0, shift_operand=12'h000.
- Busy-window start rule:
  - Start value=32'h00000080. Pulse start with value=0 in cycle 5 -> ignored; the single done appears in cycle 15 with 12'hD02.
  - A start in cycle 16 is accepted.
- Reset mid-operation:
  - Start value=32'h00000080 and assert rst in cycle 4 -> cycle 5 shows busy=0, found=0, shift_operand=0, and no done follows.
  - A subsequent start with value=0 -> done 2 cycles later, shift_operand=12'h000, found=1.

Source files
------------

// File: rtl/imm_operand_encoder.sv
// Encodes a 32-bit constant as a rotated 8-bit immediate or a 12-bit signed offset.
// Rotations are searched one per cycle, smallest first.
module imm_operand_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ld_str,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] shift_operand
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  r;
    logic [31:0] v;
    logic [31:0] w;
    logic [4:0]  sh;
    logic        fit;
    logic        off_fit;

    // Left-rotating undoes the decoder's right rotation; shift by 32 yields 0.
    always_comb begin
        sh      = {r, 1'b0};
        w       = (v << sh) | (v >> (6'd32 - {1'b0, sh}));
        fit     = (&w[31:7]) | ~(|w[31:7]);
        off_fit = (&value[31:11]) | ~(|value[31:11]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            r             <= 4'd0;
            v             <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            shift_operand <= 12'h000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        v    <= value;
                        r    <= 4'd0;
                        busy <= 1'b1;
                        if (ld_str) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            found         <= off_fit;
                            shift_operand <= off_fit ? value[11:0] : 12'h000;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (fit) begin
                        shift_operand <= {r, w[7:0]};
                        found         <= 1'b1;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (r == 4'd15) begin
                        shift_operand <= 12'h000;
                        found         <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Directed bench for imm_operand_encoder.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ld_str = 1'b0;
    logic [31:0] value = 32'd0;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] shift_operand;

    int total = 0;
    int bad = 0;

    imm_operand_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ld_str       (ld_str),
        .value        (value),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .shift_operand(shift_operand)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request in the current cycle (cycle 0) and waits for done.
    // Leaves the bench in the idle cycle after done.
    task automatic do_req(input logic [31:0] val, input logic ld,
                          output int cyc, output logic f,
                          output logic [11:0] so);
        cyc    = -1;
        f      = 1'b0;
        so     = 12'hxxx;
        start  = 1'b1;
        value  = val;
        ld_str = ld;
        for (int c = 1; c <= 25; c++) begin
            step();
            start = 1'b0;
            if (done === 1'b1) begin
                cyc = c;
                f   = found;
                so  = shift_operand;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({busy, done, found, shift_operand} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b found=%b so=%h want all 0",
                     busy, done, found, shift_operand);
        end
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_imm(input string nm, input logic [31:0] val,
                            input int ecyc, input logic ef,
                            input logic [11:0] eso);
        int          cyc;
        logic        f;
        logic [11:0] so;
        do_req(val, 1'b0, cyc, f, so);
        total++;
        if (cyc !== ecyc) begin
            bad++;
            $display("FAIL %s_cycle: got %0d want %0d", nm, cyc, ecyc);
        end
        total++;
        if (f !== ef || so !== eso) begin
            bad++;
            $display("FAIL %s_result: got found=%b so=%h want found=%b so=%h",
                     nm, f, so, ef, eso);
        end
    endtask

    task automatic test_offset();
        int          cyc;
        logic        f;
        logic [11:0] so;
        start  = 1'b1;
        value  = 32'hFFFFF800;
        ld_str = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            bad++;
            $display("FAIL off_c1: got busy=%b done=%b want 1 1", busy, done);
        end
        total++;
        if (found !== 1'b1 || shift_operand !== 12'h800) begin
            bad++;
            $display("FAIL off_neg: got found=%b so=%h want 1 800", found, shift_operand);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL off_c2: got busy=%b done=%b want 0 0", busy, done);
        end
        // Back-to-back: accepted in the cycle right after done.
        do_req(32'h00000800, 1'b1, cyc, f, so);
        total++;
        if (cyc !== 1 || f !== 1'b0 || so !== 12'h000) begin
            bad++;
            $display("FAIL off_pos: got cyc=%0d found=%b so=%h want 1 0 000", cyc, f, so);
        end
        do_req(32'h000007FF, 1'b1, cyc, f, so);
        total++;
        if (cyc !== 1 || f !== 1'b1 || so !== 12'h7FF) begin
            bad++;
            $display("FAIL off_max: got cyc=%0d found=%b so=%h want 1 1 7ff", cyc, f, so);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int dcyc  = -1;
        logic [11:0] so = 12'h000;
        start  = 1'b1;
        value  = 32'h00000080;
        ld_str = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            start = (c == 5);
            value = (c == 5) ? 32'd0 : 32'h00000080;
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
                so   = shift_operand;
            end
        end
        total++;
        if (ndone !== 1 || dcyc !== 15 || so !== 12'hD02) begin
            bad++;
            $display("FAIL busy_ignore: got ndone=%0d cyc=%0d so=%h want 1 15 d02",
                     ndone, dcyc, so);
        end
        // Now in cycle 16: start must be accepted.
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_c16: got busy=%b want 0", busy);
        end
        start = 1'b1;
        value = 32'hFFFFFF80;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL accept_c16: got busy=%b want 1", busy);
        end
        step();
        total++;
        if (done !== 1'b1 || found !== 1'b1 || shift_operand !== 12'h080) begin
            bad++;
            $display("FAIL accept_done: got done=%b found=%b so=%h want 1 1 080",
                     done, found, shift_operand);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int          ndone = 0;
        int          cyc;
        logic        f;
        logic [11:0] so;
        start  = 1'b1;
        value  = 32'h00000080;
        ld_str = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({busy, done, found, shift_operand} !== 15'd0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b done=%b found=%b so=%h want all 0",
                     busy, done, found, shift_operand);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL mid_reset_nodone: got %0d dones want 0", ndone);
        end
        do_req(32'd0, 1'b0, cyc, f, so);
        total++;
        if (cyc !== 2 || f !== 1'b1 || so !== 12'h000) begin
            bad++;
            $display("FAIL after_reset: got cyc=%0d found=%b so=%h want 2 1 000", cyc, f, so);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_imm("neg80",  32'hFFFFFF80, 2,  1'b1, 12'h080);
        test_imm("rot4",   32'h3F000000, 6,  1'b1, 12'h43F);
        test_imm("rot13",  32'h00000080, 15, 1'b1, 12'hD02);
        test_imm("nofit",  32'h000000FF, 17, 1'b0, 12'h000);
        test_imm("rot15",  32'h000001FC, 17, 1'b1, 12'hF7F);
        test_imm("rot1",   32'h0000007F, 2,  1'b1, 12'h07F);
        test_offset();
        test_busy_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
